// File: rtl/countdown_pkg.sv
// State encoding and small helpers shared by the countdown controller.
package countdown_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    CD_IDLE  = ST_IDLE,
    CD_LOAD  = ST_LOAD,
    CD_RUN   = ST_RUN,
    CD_PAUSE = ST_PAUSE,
    CD_DONE  = ST_DONE
  } cd_state_t;

  // States in which a countdown is considered active.
  function automatic logic is_busy(cd_state_t s);
    return s inside {CD_LOAD, CD_RUN, CD_PAUSE};
  endfunction

endpackage

// File: rtl/dcount_core.sv
// DW-bit down-counter register: clear beats load beats decrement; never wraps below 0.
module dcount_core #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic          dec_en,
  input  logic [DW-1:0] load_val,
  output logic [DW-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec_en && (count != '0)) begin
      count <= count - DW'(1);
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown controller: FSM around dcount_core with pause/abort.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the captured value at each zero.
import countdown_pkg::*;

module countdown_ctrl #(
  parameter int unsigned DW           = 8,
  parameter int unsigned LOAD_DEFAULT = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          use_default,
  input  logic [DW-1:0] load_val,
  input  logic          pause,
  input  logic          abort,
  output logic [DW-1:0] count,
  output logic          busy,
  output logic          done
);

  cd_state_t     state, state_nxt;
  logic [DW-1:0] v_q;
  logic          cap, ld, clr, dec, hit_zero, done_nxt;

  dcount_core #(.DW(DW)) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (clr),
    .load     (ld),
    .dec_en   (dec),
    .load_val (v_q),
    .count    (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CD_IDLE;
      v_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= is_busy(state_nxt);
      done  <= done_nxt;
      if (cap) begin
        v_q <= use_default ? DW'(LOAD_DEFAULT) : load_val;
      end
    end
  end

  // Next state and datapath controls; abort always takes priority over pause.
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    ld        = 1'b0;
    clr       = 1'b0;
    dec       = 1'b0;
    hit_zero  = 1'b0;
    case (state)
      CD_IDLE: begin
        if (start) begin
          state_nxt = CD_LOAD;
          cap       = 1'b1;
        end
      end
      CD_LOAD: begin
        if (abort) begin
          state_nxt = CD_IDLE;
          clr       = 1'b1;
        end else begin
          ld        = 1'b1;
          state_nxt = (v_q != '0) ? CD_RUN : CD_DONE;
        end
      end
      CD_RUN: begin
        if (abort) begin
          state_nxt = CD_IDLE;
          clr       = 1'b1;
        end else if (pause) begin
          state_nxt = CD_PAUSE;
        end else begin
          dec = 1'b1;
          if (count <= DW'(1)) begin
            hit_zero = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            state_nxt = CD_LOAD;
`else
            state_nxt = CD_DONE;
`endif
          end
        end
      end
      CD_PAUSE: begin
        if (abort) begin
          state_nxt = CD_IDLE;
          clr       = 1'b1;
        end else if (!pause) begin
          state_nxt = CD_RUN;
        end
      end
      CD_DONE: state_nxt = CD_IDLE;
      default: begin
        state_nxt = CD_IDLE;
        clr       = 1'b1;
      end
    endcase
    done_nxt = hit_zero || (state_nxt == CD_DONE);
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios plus random traffic vs a rule-level model.
module tb_countdown_ctrl;

  localparam int unsigned DW           = 8;
  localparam int unsigned LOAD_DEFAULT = 7;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, use_default, pause, abort;
  logic [DW-1:0] load_val;
  logic [DW-1:0] count;
  logic          busy, done;

  countdown_ctrl #(.DW(DW), .LOAD_DEFAULT(LOAD_DEFAULT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .use_default (use_default),
    .load_val    (load_val),
    .pause       (pause),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: phases named after what the user sees, not the RTL encoding.
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_HOLD, M_FIN} mph_t;
  mph_t m_ph;
  int   m_cnt, m_v;
  bit   m_busy, m_done;

  task automatic model_reset();
    m_ph = M_IDLE; m_cnt = 0; m_v = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    case (m_ph)
      M_IDLE: if (start) begin
        m_v  = use_default ? int'(LOAD_DEFAULT) : int'(load_val);
        m_ph = M_LOAD;
      end
      M_LOAD: if (abort) begin
        m_ph = M_IDLE; m_cnt = 0;
      end else begin
        m_cnt = m_v;
        if (m_v == 0) begin m_ph = M_FIN; m_done = 1; end
        else m_ph = M_RUN;
      end
      M_RUN: if (abort) begin
        m_ph = M_IDLE; m_cnt = 0;
      end else if (pause) begin
        m_ph = M_HOLD;
      end else begin
        if (m_cnt > 0) m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1;
          m_ph   = AUTO ? M_LOAD : M_FIN;
        end
      end
      M_HOLD: if (abort) begin
        m_ph = M_IDLE; m_cnt = 0;
      end else if (!pause) begin
        m_ph = M_RUN;
      end
      M_FIN: m_ph = M_IDLE;
      default: m_ph = M_IDLE;
    endcase
    m_busy = (m_ph == M_LOAD) || (m_ph == M_RUN) || (m_ph == M_HOLD);
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs sampled 1ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, "_count"}, int'(count), m_cnt);
    chk({tag, "_busy"},  int'(busy),  int'(m_busy));
    chk({tag, "_done"},  int'(done),  int'(m_done));
  endtask

  task automatic pace(input int target, input string tag);
    int k = 0;
    while (m_cnt != target && k < 64) begin
      tick(tag);
      k++;
    end
    if (k >= 64) chk({tag, "_pace_timeout"}, k, 0);
  endtask

  task automatic to_idle(input string tag);
    int k = 0;
    while (m_ph != M_IDLE && k < 64) begin
      tick(tag);
      k++;
    end
    if (k >= 64) chk({tag, "_idle_timeout"}, k, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; use_default = 1'b0; pause = 1'b0; abort = 1'b0;
    load_val = '0;
    model_reset();
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_done",  int'(done),  0);
    @(posedge clk); #1;
    reset = 1'b0;

    // V=5: 5,4,3,2,1,0 then idle
    load_val = 8'd5; start = 1'b1;
    tick("t30"); start = 1'b0;
    chk("t30_load_busy", int'(busy), 1);
    tick("t30"); chk("t30_first", int'(count), 5);
    repeat (4) tick("t30");
    tick("t30");
    chk("t30_zero", int'(count), 0);
    chk("t30_done", int'(done), 1);
    tick("t30");
    chk("t30_idle_busy", int'(busy), 0);
    chk("t30_done_off", int'(done), 0);

    // Preset start value, done 8 edges after the LOAD cycle
    use_default = 1'b1; load_val = 8'd99; start = 1'b1;
    tick("t31"); start = 1'b0; use_default = 1'b0;
    tick("t31"); n = 1;
    chk("t31_first", int'(count), 7);
    while (!done && n < 40) begin tick("t31"); n++; end
    chk("t31_done_lat", n, 8);
    to_idle("t31");

    // V=10, pause on two edges at 6; the resume edge also holds -> 6 held 3 extra cycles
    load_val = 8'd10; start = 1'b1;
    tick("t32"); start = 1'b0;
    n = 0;
    while (m_cnt != 6 && n < 40) begin tick("t32"); n++; end
    pause = 1'b1;
    repeat (2) begin tick("t32"); chk("t32_hold", int'(count), 6); n++; end
    pause = 1'b0;
    tick("t32"); chk("t32_resume_hold", int'(count), 6); n++;
    tick("t32"); chk("t32_resumed", int'(count), 5); n++;
    while (!done && n < 60) begin tick("t32"); n++; end
    chk("t32_done_lat", n, 11 + 3);
    to_idle("t32");

    // V=20: start mid-run ignored, abort at 12
    load_val = 8'd20; start = 1'b1;
    tick("t33"); start = 1'b0;
    pace(15, "t33");
    load_val = 8'd3; start = 1'b1;
    tick("t33_ign"); start = 1'b0;
    chk("t33_ignored", int'(count), 14);
    pace(12, "t33");
    abort = 1'b1;
    tick("t33_abort"); abort = 1'b0;
    chk("t33_abort_count", int'(count), 0);
    chk("t33_abort_busy",  int'(busy),  0);
    chk("t33_abort_done",  int'(done),  0);
    repeat (3) tick("t33_quiet");

    // start+abort in IDLE: start wins; abort in DONE is ignored
    load_val = 8'd3; start = 1'b1; abort = 1'b1;
    tick("t23"); start = 1'b0; abort = 1'b0;
    chk("t23_start_wins", int'(busy), 1);
    n = 0;
    while (!done && n < 20) begin tick("t23"); n++; end
    chk("t23_reached_done", int'(done), 1);
    abort = 1'b1;
    tick("t22_abort_done"); abort = 1'b0;
    chk("t22_idle_busy", int'(busy), 0);

    // V=0: LOAD then DONE straight away
    load_val = 8'd0; start = 1'b1;
    tick("t34z"); start = 1'b0;
    chk("t34z_load", int'(busy), 1);
    tick("t34z");
    chk("t34z_done",  int'(done),  1);
    chk("t34z_count", int'(count), 0);
    tick("t34z");
    chk("t34z_done_off", int'(done), 0);

    // async reset mid-run at 4, then start honoured on the next edge
    load_val = 8'd9; start = 1'b1;
    tick("t34r"); start = 1'b0;
    pace(4, "t34r");
    #2 reset = 1'b1;
    #1;
    chk("t34r_count", int'(count), 0);
    chk("t34r_busy",  int'(busy),  0);
    chk("t34r_done",  int'(done),  0);
    model_reset();
    reset = 1'b0;
    load_val = 8'd2; start = 1'b1;
    tick("t25"); start = 1'b0;
    chk("t25_first_start", int'(busy), 1);
    to_idle("t25");

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Auto reload: 3,2,1,0,3,2,1,0 with done at each zero, abort ends it
    load_val = 8'd3; start = 1'b1;
    tick("t35"); start = 1'b0;
    repeat (12) tick("t35");
    abort = 1'b1;
    tick("t35_abort"); abort = 1'b0;
    chk("t35_stopped", int'(busy), 0);
`endif

    // Random traffic
    repeat (400) begin
      start       = ($urandom_range(3) == 0);
      use_default = $urandom_range(1) != 0;
      load_val    = DW'($urandom_range(12));
      pause       = ($urandom_range(4) == 0);
      abort       = ($urandom_range(19) == 0);
      tick("rnd");
    end
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    to_idle("rnd_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter DW, default 8: count and load width in bits.
REQ-002 Parameter LOAD_DEFAULT, default 7: preset start value, used when use_default=1.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a countdown; sampled only in IDLE.
REQ-006 use_default  input  1  at start: 1 selects LOAD_DEFAULT, 0 selects load_val.
REQ-007 load_val  input  DW  start value when use_default=0.
REQ-008 pause  input  1  level; holds the count while in RUN/PAUSE.
REQ-009 abort  input  1  cancels any active countdown.
REQ-010 count  output  DW  current counter value.
REQ-011 busy  output  1  high in LOAD, RUN, PAUSE.
REQ-012 done  output  1  one-cycle pulse when the count reaches 0.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, RUN, PAUSE, DONE.
REQ-014 IDLE: count holds; start=1 -> LOAD, capturing the selected start value V in an internal register.
REQ-015 LOAD (one cycle): count <= V; next RUN if V!=0, else DONE with count=0.
REQ-016 RUN, pause=0: count decrements by 1 per cycle; the edge taking count 1->0 also enters DONE.
REQ-017 RUN, pause=1 -> PAUSE with count held that cycle; PAUSE, pause=0 -> RUN with no decrement on that edge.
REQ-018 Timing: start high at edge k -> LOAD after k; count=V after k+1; count=0 and DONE after edge k+1+V.
REQ-019 DONE: done=1 for exactly that cycle, count=0; next edge -> IDLE.
REQ-020 count SHALL never wrap below 0; no decrement occurs at 0.
REQ-021 abort in LOAD/RUN/PAUSE -> IDLE next edge, count cleared to 0, no done pulse; abort beats pause.
REQ-022 start outside IDLE SHALL be ignored; abort in IDLE/DONE has no effect.
REQ-023 Simultaneous start and abort in IDLE: start wins.

Reset
REQ-024 reset=1 SHALL immediately force IDLE, count=0, captured V=0, busy=0, done=0, regardless of state.
REQ-025 After reset deasserts, the first start is honoured on the next posedge.

Configuration
REQ-026 Macro COUNTDOWN_AUTO_RELOAD_EN defined: in RUN, the edge taking count 1->0 enters LOAD instead of DONE, done pulses with count=0, and countdowns repeat from V until abort or reset; V=0 goes to DONE as normal.
REQ-027 Macro undefined: single-shot behaviour per REQ-016/REQ-019, with no reload logic synthesized.

Structure
REQ-028 Package countdown_pkg SHALL hold the state enum typedef cd_state_t and the state encoding constants.
REQ-029 Sub-module dcount_core SHALL hold the DW-bit datapath register with load, clear, and decrement-enable controls; countdown_ctrl contains the FSM and drives those controls.

Verification
REQ-030 DW=8, load_val=5, use_default=0, start pulse -> count 5,4,3,2,1,0 on successive cycles; done high one cycle with count=0; busy low next cycle.
REQ-031 use_default=1, start -> count=7 after LOAD, done 8 cycles after the LOAD cycle.
REQ-032 V=10, pause high 3 cycles when count=6 -> count holds 6 for 3 cycles then resumes; done delayed by 3 cycles.
REQ-033 V=20, abort when count=12 -> IDLE, count=0, no done; start during RUN with load_val=3 ignored.
REQ-034 V=0 -> LOAD then DONE, done pulse, count stays 0; async reset asserted mid-RUN at count=4 -> count=0 and busy=0 before the next posedge.
REQ-035 With COUNTDOWN_AUTO_RELOAD_EN, V=3 -> count 3,2,1,0,3,2,1,0... with done on each 0; abort stops the sequence.
